ps2_key_event_ctrl: RTL and testbench

//  Sequencing controller behind the PS/2 byte receiver. Consumes raw scan-code bytes, resolves
//  E0/F0/E1 prefix sequences into single key events (make/break, extended), tracks Shift and

---
 rtl/ps2_key_event_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_ps2_key_event_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_event_ctrl.sv
// PS/2 scan-code sequencer: resolves E0/F0/E1 prefixes into key events, tracks Shift/Caps Lock,
// buffers events in a FWFT FIFO. Optional typematic repeat filter: PS2_TYPEMATIC_FILTER_EN.
module ps2_key_event_ctrl #(
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned TIMEOUT_CYC = 100000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] rx_byte_i,
   input  logic       rx_valid_i,
   output logic [9:0] ev_data_o,
   output logic       ev_valid_o,
   input  logic       ev_ready_i,
   output logic       shift_held_o,
   output logic       caps_lock_o,
   output logic       seq_err_o,
   output logic       ovf_o,
   input  logic       ovf_clr_i
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {StIdle, StExt, StBrk, StExtBrk, StSkip} state_e;

   state_e        state_q, state_d;
   logic [2:0]    skip_q, skip_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          seq_err_q;
   logic          timeout;
   logic          emit;
   logic [9:0]    emit_word;

   logic          lshift_q, lshift_d;
   logic          rshift_q, rshift_d;
   logic          caps_held_q, caps_held_d;
   logic          caps_q, caps_d;
   logic          is_mod, suppress, push;

`ifdef PS2_TYPEMATIC_FILTER_EN
   logic          held_v_q, held_v_d;
   logic [8:0]    held_key_q, held_key_d;
`endif

   logic [9:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ovf_q;
   logic          full, pop, do_push;

   // Prefix decode; a byte completing a sequence is emitted in the same cycle it arrives.
   always_comb begin
      state_d   = state_q;
      skip_d    = skip_q;
      emit      = 1'b0;
      emit_word = {2'b00, rx_byte_i};
      timeout   = 1'b0;
      if (rx_valid_i) begin
         unique case (state_q)
            StIdle: begin
               case (rx_byte_i)
                  8'hE0: state_d = StExt;
                  8'hF0: state_d = StBrk;
                  8'hE1: begin
                     state_d = StSkip;
                     skip_d  = 3'd7;
                  end
                  8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
                  end
                  default: emit = 1'b1;
               endcase
            end
            StExt: begin
               if (rx_byte_i == 8'hF0) begin
                  state_d = StExtBrk;
               end else begin
                  emit      = 1'b1;
                  emit_word = {2'b01, rx_byte_i};
                  state_d   = StIdle;
               end
            end
            StBrk: begin
               emit      = 1'b1;
               emit_word = {2'b10, rx_byte_i};
               state_d   = StIdle;
            end
            StExtBrk: begin
               emit      = 1'b1;
               emit_word = {2'b11, rx_byte_i};
               state_d   = StIdle;
            end
            StSkip: begin
               if (skip_q == 3'd1) begin
                  emit      = 1'b1;
                  emit_word = {2'b00, 8'hE1};
                  state_d   = StIdle;
               end else begin
                  skip_d = skip_q - 3'd1;
               end
            end
            default: state_d = StIdle;
         endcase
      end else if (state_q != StIdle && tmo_q == TMO_LAST) begin
         state_d = StIdle;
         timeout = 1'b1;
      end
      if (rx_valid_i || state_q == StIdle || timeout) begin
         tmo_d = '0;
      end else begin
         tmo_d = tmo_q + TW'(1);
      end
   end

   assign is_mod = !emit_word[8] &&
                   (emit_word[7:0] == 8'h12 || emit_word[7:0] == 8'h59 || emit_word[7:0] == 8'h58);

   always_comb begin
      lshift_d    = lshift_q;
      rshift_d    = rshift_q;
      caps_held_d = caps_held_q;
      caps_d      = caps_q;
      suppress    = 1'b0;
      if (emit && is_mod) begin
         case (emit_word[7:0])
            8'h12: lshift_d = !emit_word[9];
            8'h59: rshift_d = !emit_word[9];
            default: begin
               if (emit_word[9]) begin
                  caps_held_d = 1'b0;
               end else if (!caps_held_q) begin
                  caps_held_d = 1'b1;
                  caps_d      = !caps_q;
               end
            end
         endcase
      end
`ifdef PS2_TYPEMATIC_FILTER_EN
      held_v_d   = held_v_q;
      held_key_d = held_key_q;
      if (emit && !emit_word[9]) begin
         if (is_mod) begin
            suppress = (emit_word[7:0] == 8'h12 && lshift_q) ||
                       (emit_word[7:0] == 8'h59 && rshift_q) ||
                       (emit_word[7:0] == 8'h58 && caps_held_q);
         end else if (held_v_q && held_key_q == emit_word[8:0]) begin
            suppress = 1'b1;
         end else begin
            held_v_d   = 1'b1;
            held_key_d = emit_word[8:0];
         end
      end else if (emit && !is_mod && held_v_q && held_key_q == emit_word[8:0]) begin
         held_v_d = 1'b0;
      end
`endif
   end

   assign push = emit && !suppress;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         skip_q      <= '0;
         tmo_q       <= '0;
         seq_err_q   <= 1'b0;
         lshift_q    <= 1'b0;
         rshift_q    <= 1'b0;
         caps_held_q <= 1'b0;
         caps_q      <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
         held_v_q    <= 1'b0;
         held_key_q  <= '0;
`endif
      end else begin
         state_q     <= state_d;
         skip_q      <= skip_d;
         tmo_q       <= tmo_d;
         seq_err_q   <= timeout;
         lshift_q    <= lshift_d;
         rshift_q    <= rshift_d;
         caps_held_q <= caps_held_d;
         caps_q      <= caps_d;
`ifdef PS2_TYPEMATIC_FILTER_EN
         held_v_q    <= held_v_d;
         held_key_q  <= held_key_d;
`endif
      end
   end

   // FIFO: a push into a full FIFO still succeeds when the head is popped in the same cycle.
   assign ev_valid_o = (cnt_q != '0);
   assign full       = (cnt_q == FULL_CNT);
   assign pop        = ev_valid_o && ev_ready_i;
   assign do_push    = push && (!full || pop);

   always_comb begin
      cnt_d = cnt_q;
      if (do_push && !pop) begin
         cnt_d = cnt_q + CW'(1);
      end else if (!do_push && pop) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= emit_word;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         cnt_q <= cnt_d;
         if (push && full && !pop) begin
            ovf_q <= 1'b1;
         end else if (ovf_clr_i) begin
            ovf_q <= 1'b0;
         end
      end
   end

   assign ev_data_o    = ev_valid_o ? mem_q[rd_ptr_q] : 10'h000;
   assign shift_held_o = lshift_q | rshift_q;
   assign caps_lock_o  = caps_q;
   assign seq_err_o    = seq_err_q;
   assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Directed bench for ps2_key_event_ctrl; expectations are hand-computed scan-code events.
module tb_ps2_key_event_ctrl;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned TMO   = 20;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_byte;
   logic       rx_valid;
   logic [9:0] ev_data;
   logic       ev_valid;
   logic       ev_ready;
   logic       shift_held;
   logic       caps_lock;
   logic       seq_err;
   logic       ovf;
   logic       ovf_clr;

   int n_chk  = 0;
   int n_fail = 0;

   ps2_key_event_ctrl #(
      .DEPTH       (DEPTH),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .rx_byte_i    (rx_byte),
      .rx_valid_i   (rx_valid),
      .ev_data_o    (ev_data),
      .ev_valid_o   (ev_valid),
      .ev_ready_i   (ev_ready),
      .shift_held_o (shift_held),
      .caps_lock_o  (caps_lock),
      .seq_err_o    (seq_err),
      .ovf_o        (ovf),
      .ovf_clr_i    (ovf_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_byte  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic pop_chk(input string tag, input logic [9:0] exp);
      check({tag, "_valid"}, 16'(ev_valid), 16'h1);
      check({tag, "_data"}, 16'(ev_data), 16'(exp));
      ev_ready = 1'b1;
      @(negedge clk);
      ev_ready = 1'b0;
   endtask

   task automatic drain(output int n, output logic [9:0] first, output logic [9:0] last);
      n        = 0;
      first    = '0;
      last     = '0;
      ev_ready = 1'b1;
      for (int i = 0; i < int'(DEPTH) + 4; i++) begin
         if (ev_valid) begin
            if (n == 0) first = ev_data;
            last = ev_data;
            n++;
         end
         @(negedge clk);
      end
      ev_ready = 1'b0;
   endtask

   initial begin
      int         n;
      int         first_err;
      int         err_width;
      logic [9:0] f;
      logic [9:0] l;

      rst      = 1'b1;
      rx_byte  = 8'h00;
      rx_valid = 1'b0;
      ev_ready = 1'b0;
      ovf_clr  = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_valid", 16'(ev_valid), 16'h0);
      check("rst_data", 16'(ev_data), 16'h0);
      check("rst_shift", 16'(shift_held), 16'h0);
      check("rst_caps", 16'(caps_lock), 16'h0);
      check("rst_seqerr", 16'(seq_err), 16'h0);
      check("rst_ovf", 16'(ovf), 16'h0);
      rst = 1'b0;

      // Plain make, one-cycle latency, head stable while not ready
      send(8'h1C);
      check("lat_valid", 16'(ev_valid), 16'h1);
      check("lat_data", 16'(ev_data), 16'h01C);
      @(negedge clk);
      check("hold_data", 16'(ev_data), 16'h01C);
      pop_chk("make_1c", 10'h01C);
      check("empty_after_pop", 16'(ev_valid), 16'h0);

      // Prefix sequences with controller replies interleaved
      send(8'hF0); send(8'h1C); send(8'hAA);
      send(8'hE0); send(8'h75); send(8'hFA);
      send(8'hE0); send(8'hF0); send(8'h75);
      pop_chk("brk_1c", 10'h21C);
      pop_chk("ext_75", 10'h175);
      pop_chk("extbrk_75", 10'h375);
      check("empty_after_seq", 16'(ev_valid), 16'h0);

      // Shift tracking
      send(8'h12);
      check("shift_make", 16'(shift_held), 16'h1);
      send(8'h1C);
      check("shift_still", 16'(shift_held), 16'h1);
      send(8'hF0); send(8'h12);
      check("shift_brk", 16'(shift_held), 16'h0);
      pop_chk("ev_shift_mk", 10'h012);
      pop_chk("ev_1c", 10'h01C);
      pop_chk("ev_shift_brk", 10'h212);

      // Caps Lock toggle and repeat
      send(8'h58);
      check("caps_on", 16'(caps_lock), 16'h1);
      send(8'hF0); send(8'h58);
      check("caps_rel", 16'(caps_lock), 16'h1);
      send(8'h58);
      check("caps_off", 16'(caps_lock), 16'h0);
      send(8'hF0); send(8'h58);
      send(8'h58);
      check("caps_on2", 16'(caps_lock), 16'h1);
      send(8'h58);
      check("caps_repeat", 16'(caps_lock), 16'h1);
      send(8'hF0); send(8'h58);
      drain(n, f, l);
`ifdef PS2_TYPEMATIC_FILTER_EN
      check("caps_ev_cnt", 16'(n), 16'd6);
`else
      check("caps_ev_cnt", 16'(n), 16'd7);
`endif
      check("caps_ev_last", 16'(l), 16'h258);

      // Reset in the middle of an extended sequence
      send(8'h12); send(8'hE0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_shift", 16'(shift_held), 16'h0);
      check("midrst_caps", 16'(caps_lock), 16'h0);
      check("midrst_valid", 16'(ev_valid), 16'h0);
      rst = 1'b0;
      send(8'h4D);
      pop_chk("after_rst", 10'h04D);

      // Inter-byte timeout
      send(8'hE0);
      first_err = 0;
      err_width = 0;
      for (int i = 1; i <= int'(TMO) + 3; i++) begin
         @(negedge clk);
         if (seq_err) begin
            if (first_err == 0) first_err = i;
            err_width++;
         end
      end
      check("tmo_cycle", 16'(first_err), 16'(TMO));
      check("tmo_width", 16'(err_width), 16'h1);
      check("tmo_no_event", 16'(ev_valid), 16'h0);
      send(8'h1C);
      pop_chk("after_tmo", 10'h01C);

      // Overflow and push+pop while full
      for (int i = 1; i <= int'(DEPTH); i++) send(8'(i));
      check("ovf_at_full", 16'(ovf), 16'h0);
      send(8'(DEPTH + 1));
      check("ovf_set", 16'(ovf), 16'h1);
      check("ovf_head", 16'(ev_data), 16'h001);
      @(negedge clk);
      rx_byte  = 8'(DEPTH + 2);
      rx_valid = 1'b1;
      ev_ready = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      ev_ready = 1'b0;
      check("pp_full_ovf", 16'(ovf), 16'h1);
      drain(n, f, l);
      check("pp_full_cnt", 16'(n), 16'(DEPTH));
      check("pp_full_first", 16'(f), 16'h002);
      check("pp_full_last", 16'(l), 16'(DEPTH + 2));
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      check("ovf_clr", 16'(ovf), 16'h0);

      // Pause sequence collapses to one event
      send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
      send(8'hF0); send(8'h14); send(8'hF0);
      check("pause_partial", 16'(ev_valid), 16'h0);
      send(8'h77);
      drain(n, f, l);
      check("pause_cnt", 16'(n), 16'h1);
      check("pause_data", 16'(f), 16'h0E1);

      // Typematic repeat
      send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
      drain(n, f, l);
`ifdef PS2_TYPEMATIC_FILTER_EN
      check("rep_cnt", 16'(n), 16'd2);
`else
      check("rep_cnt", 16'(n), 16'd4);
`endif
      check("rep_first", 16'(f), 16'h01C);
      check("rep_last", 16'(l), 16'h21C);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
